aes_round_tail: RTL

Registered back half of one AES-128 encryption round: consumes the 128-bit state produced by `sub_bytes`, then applies ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey. It sits directly downstream of `sub_bytes` in the round datapath. Its output feeds the next round's `sub_bytes`, or becomes the ciphertext when the final flag is set. It is a two-stage valid/ready pipeline and can accept one block per cycle.

---
 rtl/aes_pkg.sv | 16 +
 rtl/mix_column.sv | 22 ++
 rtl/aes_round_tail.sv | 92 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: state width, GF(2^8) doubling and column-major byte addressing.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  // Multiply by 2 modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bit position of the LSB of byte (row r, col c); byte k = 4c+r sits at [127-8k -: 8].
  function automatic int unsigned byte_lsb(input int unsigned r, input int unsigned c);
    return AES_STATE_W - 8 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/mix_column.sv
// One AES MixColumns column, purely combinational; row 0 byte is i_col[31:24].
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_s0, w_s1, w_s2, w_s3;

  assign w_s0 = i_col[31:24];
  assign w_s1 = i_col[23:16];
  assign w_s2 = i_col[15:8];
  assign w_s3 = i_col[7:0];

  // 3*x is expressed as xtime(x) ^ x.
  assign o_col[31:24] = xtime(w_s0) ^ xtime(w_s1) ^ w_s1 ^ w_s2 ^ w_s3;
  assign o_col[23:16] = w_s0 ^ xtime(w_s1) ^ xtime(w_s2) ^ w_s2 ^ w_s3;
  assign o_col[15:8]  = w_s0 ^ w_s1 ^ xtime(w_s2) ^ xtime(w_s3) ^ w_s3;
  assign o_col[7:0]   = xtime(w_s0) ^ w_s0 ^ w_s1 ^ w_s2 ^ xtime(w_s3);

endmodule

// File: rtl/aes_round_tail.sv
// Back half of an AES-128 round (ShiftRows, MixColumns unless final, AddRoundKey) as a
// two-stage valid/ready pipeline: 2-cycle latency, 1 beat/cycle, in_ready combinational from out_ready.
module aes_round_tail
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [AES_STATE_W-1:0] in_key,
  input  logic                   in_final,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   out_final,
  output logic [15:0]            blk_count
);

  logic [AES_STATE_W-1:0] w_sr;
  logic [AES_STATE_W-1:0] w_mc;
  logic                   w_a_load;
  logic                   w_b_load;

  logic                   r_a_vld;
  logic [AES_STATE_W-1:0] r_a_state;
  logic [AES_STATE_W-1:0] r_a_key;
  logic                   r_a_final;
  logic                   r_b_vld;
  logic [AES_STATE_W-1:0] r_b_state;
  logic                   r_b_final;
  logic [15:0]            r_blk_count;

  // ShiftRows: output (r,c) takes input (r,(c+r) mod 4).
  always_comb begin
    w_sr = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        w_sr[byte_lsb(r, c) +: 8] = in_state[byte_lsb(r, (c + r) % 4) +: 8];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_mix
    mix_column u_mix_column (
      .i_col (w_sr[AES_STATE_W-1-32*g -: 32]),
      .o_col (w_mc[AES_STATE_W-1-32*g -: 32])
    );
  end

  assign w_b_load = !r_b_vld || out_ready;
  assign w_a_load = !r_a_vld || w_b_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_vld     <= 1'b0;
      r_a_state   <= '0;
      r_a_key     <= '0;
      r_a_final   <= 1'b0;
      r_b_vld     <= 1'b0;
      r_b_state   <= '0;
      r_b_final   <= 1'b0;
      r_blk_count <= '0;
    end else begin
      if (w_a_load) begin
        r_a_vld <= in_valid;
        if (in_valid) begin
          r_a_state <= in_final ? w_sr : w_mc;
          r_a_key   <= in_key;
          r_a_final <= in_final;
        end
      end
      if (w_b_load) begin
        r_b_vld <= r_a_vld;
        if (r_a_vld) begin
          r_b_state <= r_a_state ^ r_a_key;
          r_b_final <= r_a_final;
        end
      end
      if (r_b_vld && out_ready && r_b_final) begin
        r_blk_count <= r_blk_count + 16'd1;
      end
    end
  end

  assign in_ready  = w_a_load;
  assign out_valid = r_b_vld;
  assign out_state = r_b_state;
  assign out_final = r_b_final;
  assign blk_count = r_blk_count;

endmodule
